// File: rtl/life_engine_param_if.sv
`default_nettype none
// ============================================================================
// Module   : life_engine_param_if
// Purpose  : Control, seeding and display-read bundle between the user
//            controls / pixel generator (master) and the Life engine (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface life_engine_param_if #(
    parameter int BIT_WIDTH  = 3,
    parameter int BIT_HEIGHT = 3
);
    localparam int c_AW = BIT_WIDTH + BIT_HEIGHT;

    logic            frame_tick;
    logic            run;
    logic            step;
    logic            clear;
    logic            wr_en;
    logic [c_AW-1:0] wr_addr;
    logic            wr_data;
    logic [c_AW-1:0] rd_addr;
    logic            rd_data;
    logic            busy;
    logic            gen_done;
    logic [15:0]     gen_count;
    logic [c_AW:0]   alive_count;

    modport master (
        output frame_tick, run, step, clear, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, gen_done, gen_count, alive_count
    );

    modport slave (
        input  frame_tick, run, step, clear, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, gen_done, gen_count, alive_count
    );
endinterface
`default_nettype wire

// File: rtl/life_engine_param.sv
`default_nettype none
// ============================================================================
// Module   : life_engine_param
// Purpose  : Double-buffered Conway Game-of-Life engine, one cell per clock.
//            Display reads the front bank combinationally while the back bank
//            is computed; banks swap atomically at the end of a generation.
//            Optional macro LIFE_POPCOUNT_EN enables the live-cell counter.
// Revision : 1.0 - initial release
// ============================================================================
module life_engine_param #(
    parameter int BIT_WIDTH      = 3,
    parameter int BIT_HEIGHT     = 3,
    parameter int WRAP           = 0,
    parameter int FRAMES_PER_GEN = 60
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    life_engine_param_if.slave bus
);
    localparam int c_AW   = BIT_WIDTH + BIT_HEIGHT;
    localparam int c_SIZE = 1 << c_AW;
    localparam int c_W    = 1 << BIT_WIDTH;
    localparam int c_H    = 1 << BIT_HEIGHT;
    localparam int c_FW   = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;
    localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(FRAMES_PER_GEN - 1);
    localparam logic [c_AW-1:0] c_LAST_IDX   = {c_AW{1'b1}};

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COMPUTE = 2'd1;
    localparam logic [1:0] c_SWAP    = 2'd2;
    localparam logic [1:0] c_CLEAR   = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [c_SIZE-1:0] r_bank_a;
    logic [c_SIZE-1:0] r_bank_b;
    logic              r_front_sel;
    logic [c_AW-1:0]   r_index;
    logic [c_FW-1:0]   r_frame_cnt;
    logic [15:0]       r_gen_count;
    logic              r_gen_done;

    logic [c_SIZE-1:0] w_front_bank;
    logic              w_auto_req;
    logic              w_cell_wr;
    logic [3:0]        w_ncount;
    logic              w_next_cell;
    int                w_row_i;
    int                w_col_i;
    logic [c_AW-1:0]   w_nb_addr;

    assign w_front_bank = r_front_sel ? r_bank_b : r_bank_a;
    assign w_auto_req   = bus.run & bus.frame_tick & (r_frame_cnt == c_FRAME_LAST);
    // Seeding only touches the board while idle, and a same-cycle clear wins.
    assign w_cell_wr    = (r_state == c_IDLE) & bus.wr_en & ~bus.clear;

    assign bus.rd_data   = w_front_bank[bus.rd_addr];
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.gen_done  = r_gen_done;
    assign bus.gen_count = r_gen_count;

    // Frame divider: counts ticks while running, raises the auto request on the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (!bus.run) begin
            r_frame_cnt <= '0;
        end else if (bus.frame_tick) begin
            r_frame_cnt <= (r_frame_cnt == c_FRAME_LAST) ? '0 : r_frame_cnt + c_FW'(1);
        end
    end

    // Next-state logic; clear outranks step/auto, and requests arriving while busy are dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.clear)                   w_state_next = c_CLEAR;
                else if (bus.step || w_auto_req) w_state_next = c_COMPUTE;
            end
            c_COMPUTE: begin
                if (bus.clear)                    w_state_next = c_CLEAR;
                else if (r_index == c_LAST_IDX)   w_state_next = c_SWAP;
            end
            c_SWAP:  w_state_next = c_IDLE;
            c_CLEAR: w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Neighbour count of the current cell; off-board neighbours are dead unless wrapping.
    always_comb begin
        w_ncount  = '0;
        w_row_i   = 0;
        w_col_i   = 0;
        w_nb_addr = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (dr != 0 || dc != 0) begin
                    w_row_i   = int'(r_index[c_AW-1:BIT_WIDTH]) + dr;
                    w_col_i   = int'(r_index[BIT_WIDTH-1:0]) + dc;
                    // Truncation to the field width gives the toroidal wrap for free.
                    w_nb_addr = {w_row_i[BIT_HEIGHT-1:0], w_col_i[BIT_WIDTH-1:0]};
                    if (WRAP != 0 ||
                        (w_row_i >= 0 && w_row_i < c_H && w_col_i >= 0 && w_col_i < c_W)) begin
                        w_ncount = w_ncount + {3'b000, w_front_bank[w_nb_addr]};
                    end
                end
            end
        end
    end

    assign w_next_cell = (w_ncount == 4'd3) | (w_front_bank[r_index] & (w_ncount == 4'd2));

    // Cell storage: compute writes the back bank, seeding writes the front bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_a <= '0;
            r_bank_b <= '0;
        end else if (r_state == c_CLEAR) begin
            r_bank_a <= '0;
            r_bank_b <= '0;
        end else if (r_state == c_COMPUTE) begin
            if (r_front_sel) r_bank_a[r_index] <= w_next_cell;
            else             r_bank_b[r_index] <= w_next_cell;
        end else if (w_cell_wr) begin
            if (r_front_sel) r_bank_b[bus.wr_addr] <= bus.wr_data;
            else             r_bank_a[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sequencer registers: state, scan index, bank select and generation bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_index     <= '0;
            r_front_sel <= 1'b0;
            r_gen_count <= '0;
            r_gen_done  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_gen_done <= (r_state == c_SWAP);
            r_index    <= (r_state == c_COMPUTE) ? r_index + c_AW'(1) : '0;
            if (r_state == c_SWAP) begin
                r_front_sel <= ~r_front_sel;
                r_gen_count <= r_gen_count + 16'd1;
            end
        end
    end

`ifdef LIFE_POPCOUNT_EN
    logic [c_AW:0] r_acc;
    logic [c_AW:0] r_alive;

    // Live-cell tracking: accumulate during compute, publish at swap, follow idle seeding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_alive <= '0;
        end else begin
            case (r_state)
                c_COMPUTE: r_acc <= r_acc + {{c_AW{1'b0}}, w_next_cell};
                c_SWAP: begin
                    r_alive <= r_acc;
                    r_acc   <= '0;
                end
                c_CLEAR: begin
                    r_alive <= '0;
                    r_acc   <= '0;
                end
                default: begin
                    if (w_cell_wr && (bus.wr_data != w_front_bank[bus.wr_addr])) begin
                        r_alive <= bus.wr_data ? r_alive + (c_AW+1)'(1) : r_alive - (c_AW+1)'(1);
                    end
                end
            endcase
        end
    end

    assign bus.alive_count = r_alive;
`else
    assign bus.alive_count = '0;
`endif
endmodule
`default_nettype wire
